// File: rtl/rv32_pkg.sv
// Shared types for the RV32 memory arbiter: FSM state encoding and the
// captured request payload.
package rv32_pkg;

    // Payload address is stored at a fixed maximum width; ports narrow it.
    localparam int unsigned REQ_ADDR_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                      wr;
        logic [3:0]                be;
        logic [REQ_ADDR_MAX_W-1:0] addr;
        logic [31:0]               wdata;
    } mem_req_t;

endpackage

// File: rtl/rv32_mod_req_slot.sv
// One-deep pending slot for a single requester. Publishes its next-cycle
// contents so the arbiter can issue a request on the same edge it lands.
module rv32_mod_req_slot
    import rv32_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     req,
    input  mem_req_t req_in,
    input  logic     free,
    output logic     valid_nxt,
    output mem_req_t data_nxt,
    output logic     drop
);

    logic     valid_q, valid_d;
    mem_req_t data_q, data_d;
    logic     keep;

    // A slot being freed this edge is treated as empty, so a new req lands.
    always_comb begin
        keep    = valid_q & ~free;
        drop    = req & keep;
        valid_d = keep | req;
        data_d  = (req & ~keep) ? req_in : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_nxt = valid_d;
    assign data_nxt  = data_d;

endmodule

// File: rtl/rv32_mod_mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one external memory master.
// Grant policy when both pending: data first, or round robin with RV32_ARB_ROUND_ROBIN_EN.
module rv32_mod_mem_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic              i_wr,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_do,
    output logic [31:0]       i_di,
    output logic              i_ack,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_do,
    output logic [31:0]       d_di,
    output logic              d_ack,
    output logic              d_err,

    output logic              dext_req,
    output logic              dext_wr,
    output logic [3:0]        dext_be,
    output logic [ADDR_W-1:0] dext_addr,
    output logic [31:0]       dext_do,
    input  logic [31:0]       dext_di,
    input  logic              dext_ack,
    input  logic              dext_err,

    output logic              owner_d,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    mem_req_t i_in, d_in, i_nxt, d_nxt, sel;
    logic     i_valid_nxt, d_valid_nxt, i_drop, d_drop, i_free, d_free;
    logic     done, issue, grant_data;

    arb_state_e        state_q, state_d;
    logic              dext_req_q, dext_req_d;
    logic              dext_wr_q, dext_wr_d;
    logic [3:0]        dext_be_q, dext_be_d;
    logic [ADDR_W-1:0] dext_addr_q, dext_addr_d;
    logic [31:0]       dext_do_q, dext_do_d;
    logic              overrun_q, overrun_d;

    assign i_in = '{wr: i_wr, be: i_be, addr: REQ_ADDR_MAX_W'(i_addr), wdata: i_do};
    assign d_in = '{wr: d_wr, be: d_be, addr: REQ_ADDR_MAX_W'(d_addr), wdata: d_do};

    rv32_mod_req_slot u_slot_i (
        .clk       (clk),
        .reset     (reset),
        .req       (i_req),
        .req_in    (i_in),
        .free      (i_free),
        .valid_nxt (i_valid_nxt),
        .data_nxt  (i_nxt),
        .drop      (i_drop)
    );

    rv32_mod_req_slot u_slot_d (
        .clk       (clk),
        .reset     (reset),
        .req       (d_req),
        .req_in    (d_in),
        .free      (d_free),
        .valid_nxt (d_valid_nxt),
        .data_nxt  (d_nxt),
        .drop      (d_drop)
    );

    assign done   = dext_ack | dext_err;
    assign i_free = (state_q == ST_BUSY_I) & done;
    assign d_free = (state_q == ST_BUSY_D) & done;
    // Issue from IDLE or back-to-back on the completing edge.
    assign issue  = ((state_q == ST_IDLE) | i_free | d_free) & (i_valid_nxt | d_valid_nxt);

`ifdef RV32_ARB_ROUND_ROBIN_EN
    logic last_data_q, last_data_d;

    assign grant_data = d_valid_nxt & (~i_valid_nxt | ~last_data_q);

    always_comb begin
        last_data_d = last_data_q;
        if (issue) last_data_d = grant_data;
    end

    always_ff @(posedge clk) begin
        if (reset) last_data_q <= 1'b0;
        else       last_data_q <= last_data_d;
    end
`else
    assign grant_data = d_valid_nxt;
`endif

    always_comb begin
        sel         = grant_data ? d_nxt : i_nxt;
        state_d     = state_q;
        dext_req_d  = 1'b0;
        dext_wr_d   = dext_wr_q;
        dext_be_d   = dext_be_q;
        dext_addr_d = dext_addr_q;
        dext_do_d   = dext_do_q;
        overrun_d   = i_drop | d_drop;
        if (issue) begin
            state_d     = grant_data ? ST_BUSY_D : ST_BUSY_I;
            dext_req_d  = 1'b1;
            dext_wr_d   = sel.wr;
            dext_be_d   = sel.be;
            dext_addr_d = ADDR_W'(sel.addr);
            dext_do_d   = sel.wdata;
        end else if (i_free | d_free) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dext_req_q  <= 1'b0;
            dext_wr_q   <= 1'b0;
            dext_be_q   <= 4'd0;
            dext_addr_q <= '0;
            dext_do_q   <= 32'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dext_req_q  <= dext_req_d;
            dext_wr_q   <= dext_wr_d;
            dext_be_q   <= dext_be_d;
            dext_addr_q <= dext_addr_d;
            dext_do_q   <= dext_do_d;
            overrun_q   <= overrun_d;
        end
    end

    // Response routing is combinational; an error always wins over ack.
    always_comb begin
        i_ack = 1'b0;
        i_err = 1'b0;
        i_di  = 32'd0;
        d_ack = 1'b0;
        d_err = 1'b0;
        d_di  = 32'd0;
        if (!reset) begin
            case (state_q)
                ST_BUSY_I: begin
                    i_ack = dext_ack & ~dext_err;
                    i_err = dext_err;
                    i_di  = dext_di;
                end
                ST_BUSY_D: begin
                    d_ack = dext_ack & ~dext_err;
                    d_err = dext_err;
                    d_di  = dext_di;
                end
                default: ;
            endcase
        end
    end

    assign dext_req  = dext_req_q;
    assign dext_wr   = dext_wr_q;
    assign dext_be   = dext_be_q;
    assign dext_addr = dext_addr_q;
    assign dext_do   = dext_do_q;
    assign overrun   = overrun_q;
    assign owner_d   = (state_q == ST_BUSY_D);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rv32_mod_mem_arbiter.sv
// Bench for rv32_mod_mem_arbiter: directed scenarios plus a random phase,
// all cycles cross-checked against a transaction-level reference model.
module tb_rv32_mod_mem_arbiter;
    import rv32_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req, i_wr, d_req, d_wr;
    logic [3:0]        i_be, d_be;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [31:0]       i_do, d_do, i_di, d_di;
    logic              i_ack, i_err, d_ack, d_err;
    logic              dext_req, dext_wr, dext_ack, dext_err;
    logic [3:0]        dext_be;
    logic [ADDR_W-1:0] dext_addr;
    logic [31:0]       dext_do, dext_di;
    logic              owner_d, overrun;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    rv32_mod_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_be(i_be), .i_addr(i_addr), .i_do(i_do),
        .i_di(i_di), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_wr(d_wr), .d_be(d_be), .d_addr(d_addr), .d_do(d_do),
        .d_di(d_di), .d_ack(d_ack), .d_err(d_err),
        .dext_req(dext_req), .dext_wr(dext_wr), .dext_be(dext_be), .dext_addr(dext_addr),
        .dext_do(dext_do), .dext_di(dext_di), .dext_ack(dext_ack), .dext_err(dext_err),
        .owner_d(owner_d), .overrun(overrun), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: 0 = instruction requester, 1 = data requester.
    int          owner = -1;
    bit          pv[2];
    logic        pwr[2];
    logic [3:0]  pbe[2];
    logic [31:0] paddr[2], pdo[2];
    bit          last_was_d = 0;
    logic        exp_req = 0, exp_ov = 0, h_wr = 0;
    logic [3:0]  h_be = 0;
    logic [31:0] h_addr = 0, h_do = 0;
    int          obs_order[4];
    int          exp_order[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int choose();
        if (pv[0] && pv[1]) begin
`ifdef RV32_ARB_ROUND_ROBIN_EN
            return last_was_d ? 0 : 1;
`else
            return 1;
`endif
        end
        return pv[1] ? 1 : 0;
    endfunction

    task automatic model_edge();
        bit   done;
        bit   rq[2];
        int   pick;
        if (reset) begin
            pv[0] = 0; pv[1] = 0; owner = -1; last_was_d = 0;
            exp_req = 0; exp_ov = 0; h_wr = 0; h_be = 0; h_addr = 0; h_do = 0;
            return;
        end
        rq[0] = i_req; rq[1] = d_req;
        done = (owner >= 0) && (dext_ack || dext_err);
        if (done) pv[owner] = 0;
        exp_ov = 0;
        for (int r = 0; r < 2; r++) begin
            if (rq[r]) begin
                if (pv[r]) exp_ov = 1;
                else begin
                    pv[r]    = 1;
                    pwr[r]   = (r == 0) ? i_wr : d_wr;
                    pbe[r]   = (r == 0) ? i_be : d_be;
                    paddr[r] = (r == 0) ? i_addr : d_addr;
                    pdo[r]   = (r == 0) ? i_do : d_do;
                end
            end
        end
        exp_req = 0;
        if (owner < 0 || done) begin
            if (pv[0] || pv[1]) begin
                pick = choose();
                owner = pick; exp_req = 1; last_was_d = (pick == 1);
                h_wr = pwr[pick]; h_be = pbe[pick]; h_addr = paddr[pick]; h_do = pdo[pick];
            end else begin
                owner = -1;
            end
        end
    endtask

    task automatic check_comb();
        bit oi, od;
        oi = !reset && owner == 0;
        od = !reset && owner == 1;
        chk("i_ack", i_ack, oi && dext_ack && !dext_err);
        chk("i_err", i_err, oi && dext_err);
        chk("i_di",  i_di,  oi ? dext_di : 32'd0);
        chk("d_ack", d_ack, od && dext_ack && !dext_err);
        chk("d_err", d_err, od && dext_err);
        chk("d_di",  d_di,  od ? dext_di : 32'd0);
    endtask

    task automatic check_regs();
        chk("dext_req",  dext_req,  exp_req);
        chk("dext_wr",   dext_wr,   h_wr);
        chk("dext_be",   dext_be,   h_be);
        chk("dext_addr", dext_addr, h_addr);
        chk("dext_do",   dext_do,   h_do);
        chk("owner_d",   owner_d,   owner == 1);
        chk("overrun",   overrun,   exp_ov);
    endtask

    task automatic cycle();
        #2;
        check_comb();
        model_edge();
        @(posedge clk);
        #1;
        check_regs();
        i_req = 0; d_req = 0; dext_ack = 0; dext_err = 0;
    endtask

    task automatic drive_i(input logic [31:0] addr, input logic wr);
        i_req = 1; i_wr = wr; i_be = 4'($urandom); i_addr = addr; i_do = $urandom;
    endtask

    task automatic drive_d(input logic [31:0] addr, input logic wr);
        d_req = 1; d_wr = wr; d_be = 4'($urandom); d_addr = addr; d_do = $urandom;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && owner >= 0; n++) begin
            dext_ack = 1;
            dext_di  = $urandom;
            cycle();
        end
        chk("drain_owner_d", owner_d, 1'b0);
        chk("drain_state", dbg_state, ST_IDLE);
    endtask

    initial begin
        reset = 1;
        i_req = 0; i_wr = 0; i_be = 0; i_addr = 0; i_do = 0;
        d_req = 0; d_wr = 0; d_be = 0; d_addr = 0; d_do = 0;
        dext_di = 0; dext_ack = 0; dext_err = 0;
        cycle();
        cycle();
        reset = 0;

        // Lone read: one-cycle issue latency, same-cycle response routing.
        drive_d(32'h100, 0);
        cycle();
        chk("lone_dext_req", dext_req, 1'b1);
        chk("lone_dext_addr", dext_addr, 32'h100);
        dext_ack = 1; dext_di = 32'hDEADBEEF;
        #1;
        chk("lone_d_ack", d_ack, 1'b1);
        chk("lone_d_di", d_di, 32'hDEADBEEF);
        chk("lone_i_ack", i_ack, 1'b0);
        cycle();
        chk("lone_idle_req", dext_req, 1'b0);

        // Simultaneous requests after reset: data first, instruction right after its ack.
        do_reset();
        drive_i(32'h400, 0);
        drive_d(32'h500, 1);
        cycle();
        chk("sim_first_owner_d", owner_d, 1'b1);
        chk("sim_first_addr", dext_addr, 32'h500);
        dext_ack = 1;
        cycle();
        chk("sim_second_req", dext_req, 1'b1);
        chk("sim_second_owner_d", owner_d, 1'b0);
        chk("sim_second_addr", dext_addr, 32'h400);
        dext_ack = 1;
        cycle();
        chk("sim_done_req", dext_req, 1'b0);

        // Both requesters re-request at every completion; observe grant order.
        do_reset();
`ifdef RV32_ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        drive_i($urandom & 32'hFFFF_FFFC, 0);
        drive_d($urandom & 32'hFFFF_FFFC, 0);
        cycle();
        obs_order[0] = owner_d ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            dext_ack = 1;
            drive_i($urandom & 32'hFFFF_FFFC, 0);
            drive_d($urandom & 32'hFFFF_FFFC, 1);
            cycle();
            chk("order_req", dext_req, 1'b1);
            obs_order[k+1] = owner_d ? 1 : 0;
        end
        for (int k = 0; k < 4; k++) chk($sformatf("order_%0d", k), obs_order[k], exp_order[k]);
        drain();

        // Overrun: second i_req while the first waits behind a data transfer.
        do_reset();
        drive_i(32'h600, 0);
        drive_d(32'h700, 0);
        cycle();
        drive_i(32'h680, 1);
        cycle();
        chk("ovr_pulse", overrun, 1'b1);
        chk("ovr_no_issue", dext_req, 1'b0);
        dext_ack = 1;
        cycle();
        chk("ovr_pulse_gone", overrun, 1'b0);
        chk("ovr_issue", dext_req, 1'b1);
        chk("ovr_orig_addr", dext_addr, 32'h600);
        dext_ack = 1;
        cycle();

        // Error completion on the instruction side, then a stray ack in IDLE.
        do_reset();
        drive_i(32'h200, 0);
        cycle();
        dext_err = 1;
        #1;
        chk("err_i_err", i_err, 1'b1);
        chk("err_i_ack", i_ack, 1'b0);
        chk("err_d_err", d_err, 1'b0);
        cycle();
        chk("err_state_idle", dbg_state, ST_IDLE);
        chk("err_owner_d", owner_d, 1'b0);
        dext_ack = 1;
        #1;
        chk("idle_stray_ack", i_ack, 1'b0);
        cycle();

        // Ack and err together count as an error.
        drive_i(32'h240, 1);
        cycle();
        dext_ack = 1; dext_err = 1;
        #1;
        chk("both_i_ack", i_ack, 1'b0);
        chk("both_i_err", i_err, 1'b1);
        cycle();

        // Reset while BUSY_D; the late ack must be ignored.
        drive_d(32'h300, 1);
        cycle();
        chk("rst_busy_d", owner_d, 1'b1);
        reset = 1;
        cycle();
        reset = 0;
        dext_ack = 1; dext_di = 32'h1234_5678;
        #1;
        chk("rst_late_d_ack", d_ack, 1'b0);
        chk("rst_late_d_di", d_di, 32'd0);
        cycle();
        chk("rst_out_req", dext_req, 1'b0);
        chk("rst_out_addr", dext_addr, 32'd0);
        chk("rst_out_wr", dext_wr, 1'b0);
        chk("rst_out_owner", owner_d, 1'b0);

        // Random traffic with a random responder, checked by the model every cycle.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) drive_i($urandom & 32'hFFFF_FFFC, 1'($urandom));
            if ($urandom_range(0, 3) == 0) drive_d($urandom & 32'hFFFF_FFFC, 1'($urandom));
            dext_di = $urandom;
            if (owner >= 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    dext_ack = ($urandom_range(0, 7) != 0);
                    dext_err = !dext_ack || ($urandom_range(0, 7) == 0);
                end
            end else begin
                dext_ack = ($urandom_range(0, 9) == 0);
            end
            reset = ($urandom_range(0, 99) == 0);
            cycle();
            reset = 0;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
